// File: rtl/traffic_light_ctl_gen.sv
// Two-direction traffic light controller with pedestrian green truncation,
// flashing-yellow night mode and per-direction countdown timers.

package traffic_light_ctl_gen_pkg;
  typedef enum logic [2:0] {
    ST_G0    = 3'd0,
    ST_Y0    = 3'd1,
    ST_AR0   = 3'd2,
    ST_G1    = 3'd3,
    ST_Y1    = 3'd4,
    ST_AR1   = 3'd5,
    ST_NIGHT = 3'd6,
    ST_BAD   = 3'd7
  } state_t;
endpackage

module traffic_light_ctl_gen
  import traffic_light_ctl_gen_pkg::*;
#(
  parameter int TW       = 7,
  parameter int G0_TIME  = 10,
  parameter int G1_TIME  = 13,
  parameter int Y_TIME   = 3,
  parameter int AR_TIME  = 1,
  parameter int PED_MIN  = 2,
  parameter int TICK_DIV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          night,
  input  logic [1:0]    ped_req,
  output logic [TW-1:0] timer0,
  output logic [TW-1:0] timer1,
  output logic [2:0]    tf0,
  output logic [2:0]    tf1,
  output logic [2:0]    state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // Phase counter load values (duration - 1)
  localparam logic [TW-1:0] G0_LD  = TW'(G0_TIME - 1);
  localparam logic [TW-1:0] G1_LD  = TW'(G1_TIME - 1);
  localparam logic [TW-1:0] Y_LD   = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] AR_LD  = TW'(AR_TIME - 1);
  localparam logic [TW-1:0] PED_LD = TW'(PED_MIN);

  // Offsets from CNT to "ticks until my green - 1" for the waiting direction.
  // Sums wrap modulo 2^TW; legal parameters keep them below 2^TW.
  localparam logic [TW-1:0] OFS_AR   = TW'(AR_TIME);
  localparam logic [TW-1:0] OFS_YAR  = TW'(Y_TIME + AR_TIME);
  localparam logic [TW-1:0] OFS_G0YA = TW'(G0_TIME + Y_TIME + AR_TIME);
  localparam logic [TW-1:0] OFS_G1YA = TW'(G1_TIME + Y_TIME + AR_TIME);

  state_t          state_r, state_n;
  logic [TW-1:0]   cnt_r, cnt_n;
  logic [PW-1:0]   pre_r, pre_n;
  logic            blink_r, blink_n;
  logic            tick;
  logic            last;
  logic [TW-1:0]   dec;

  // Tick strobe, end-of-phase flag and decremented count
  always_comb begin
    tick = en && (pre_r == PRE_LAST);
    last = tick && (cnt_r == {TW{1'b0}});
    dec  = cnt_r - TW'(1);
  end

  // Next-state logic: prescaler, phase sequencing, pedestrian truncation, night mode
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    pre_n   = pre_r;
    blink_n = blink_r;
    if (state_r == ST_BAD) begin
      // Recovery from a corrupted encoding does not wait for EN
      state_n = ST_AR1;
      cnt_n   = AR_LD;
      blink_n = 1'b0;
    end else if (en) begin
      pre_n = tick ? {PW{1'b0}} : (pre_r + PW'(1));
      case (state_r)
        ST_G0: begin
          if (ped_req[0] && (cnt_r > PED_LD)) begin
            cnt_n = PED_LD;
          end else if (last) begin
            state_n = ST_Y0;
            cnt_n   = Y_LD;
          end else if (tick) begin
            cnt_n = dec;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_Y0: begin
          if (last) begin
            state_n = ST_AR0;
            cnt_n   = AR_LD;
          end else if (tick) begin
            cnt_n = dec;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_AR0: begin
          if (last) begin
            if (night) begin
              state_n = ST_NIGHT;
              cnt_n   = {TW{1'b0}};
              blink_n = 1'b1;
            end else begin
              state_n = ST_G1;
              cnt_n   = G1_LD;
            end
          end else if (tick) begin
            cnt_n = dec;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_G1: begin
          if (ped_req[1] && (cnt_r > PED_LD)) begin
            cnt_n = PED_LD;
          end else if (last) begin
            state_n = ST_Y1;
            cnt_n   = Y_LD;
          end else if (tick) begin
            cnt_n = dec;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_Y1: begin
          if (last) begin
            state_n = ST_AR1;
            cnt_n   = AR_LD;
          end else if (tick) begin
            cnt_n = dec;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_AR1: begin
          if (last) begin
            if (night) begin
              state_n = ST_NIGHT;
              cnt_n   = {TW{1'b0}};
              blink_n = 1'b1;
            end else begin
              state_n = ST_G0;
              cnt_n   = G0_LD;
            end
          end else if (tick) begin
            cnt_n = dec;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_NIGHT: begin
          if (tick) begin
            if (!night) begin
              state_n = ST_AR1;
              cnt_n   = AR_LD;
              blink_n = 1'b0;
            end else begin
              blink_n = ~blink_r;
            end
          end else begin
            blink_n = blink_r;
          end
        end
        default: begin
          state_n = ST_AR1;
          cnt_n   = AR_LD;
          blink_n = 1'b0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, phase counter, prescaler and blink registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_G0;
      cnt_r   <= G0_LD;
      pre_r   <= {PW{1'b0}};
      blink_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      pre_r   <= pre_n;
      blink_r <= blink_n;
    end
  end

  // Lamp and countdown decode straight from the registered state
  always_comb begin
    tf0    = 3'b100;
    tf1    = 3'b100;
    timer0 = {TW{1'b0}};
    timer1 = {TW{1'b0}};
    case (state_r)
      ST_G0: begin
        tf0    = 3'b001;
        timer0 = cnt_r;
        timer1 = cnt_r + OFS_YAR;
      end
      ST_Y0: begin
        tf0    = 3'b010;
        timer0 = cnt_r;
        timer1 = cnt_r + OFS_AR;
      end
      ST_AR0: begin
        timer0 = cnt_r + OFS_G1YA;
        timer1 = cnt_r;
      end
      ST_G1: begin
        tf1    = 3'b001;
        timer0 = cnt_r + OFS_YAR;
        timer1 = cnt_r;
      end
      ST_Y1: begin
        tf1    = 3'b010;
        timer0 = cnt_r + OFS_AR;
        timer1 = cnt_r;
      end
      ST_AR1: begin
        timer0 = cnt_r;
        timer1 = cnt_r + OFS_G0YA;
      end
      ST_NIGHT: begin
        tf0 = {1'b0, blink_r, 1'b0};
        tf1 = {1'b0, blink_r, 1'b0};
      end
      default: begin
        tf0 = 3'b100;
        tf1 = 3'b100;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_traffic_light_ctl_gen.sv
// Self-checking bench for traffic_light_ctl_gen: constant vector table,
// hand-written corner sequences and a randomized run against a phase-list model.

module tb_traffic_light_ctl_gen;

  localparam int G0_T = 10;
  localparam int G1_T = 13;
  localparam int Y_T  = 3;
  localparam int AR_T = 1;
  localparam int PED_M = 2;
  localparam int M_DIV = 1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       night;
  logic [1:0] ped;
  logic [6:0] t0, t1;
  logic [2:0] tf0, tf1, st;

  logic       en4;
  logic       night4;
  logic [1:0] ped4;
  logic [6:0] t40, t41;
  logic [2:0] tf40, tf41, st4;

  int checks = 0;
  int errors = 0;

  // Model state: phase index 0..5 follows G0,Y0,AR0,G1,Y1,AR1; 6 night; 7 corrupt
  int m_phase, m_cnt, m_pre;
  bit m_blink;
  int dur[6];

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [2:0] tf0;
    logic [2:0] tf1;
    logic [6:0] t0;
    logic [6:0] t1;
  } vec_t;
  vec_t tab[10];

  traffic_light_ctl_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .night(night), .ped_req(ped),
    .timer0(t0), .timer1(t1), .tf0(tf0), .tf1(tf1), .state(st)
  );

  traffic_light_ctl_gen #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .night(night4), .ped_req(ped4),
    .timer0(t40), .timer1(t41), .tf0(tf40), .tf1(tf41), .state(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = G0_T - 1;
    m_pre   = 0;
    m_blink = 1'b0;
  endtask

  task automatic model_edge();
    bit tk;
    if (!rst_n) begin
      model_reset();
    end else if (m_phase == 7) begin
      m_phase = 5; m_cnt = AR_T - 1; m_blink = 1'b0;
    end else if (en) begin
      tk = (m_pre == M_DIV - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if ((m_phase == 0 || m_phase == 3) && ped[m_phase / 3] && m_cnt > PED_M) begin
        m_cnt = PED_M;
      end else if (tk) begin
        if (m_phase == 6) begin
          if (!night) begin m_phase = 5; m_cnt = AR_T - 1; m_blink = 1'b0; end
          else m_blink = ~m_blink;
        end else if (m_cnt > 0) begin
          m_cnt--;
        end else if ((m_phase == 2 || m_phase == 5) && night) begin
          m_phase = 6; m_cnt = 0; m_blink = 1'b1;
        end else begin
          m_phase = (m_phase + 1) % 6;
          m_cnt = dur[m_phase] - 1;
        end
      end
    end
  endtask

  // Expected {state, tf0, tf1, timer0, timer1}: a direction that owns the
  // phase shows CNT; a waiting one shows CNT plus all phases before its green.
  function automatic logic [22:0] model_out();
    logic [2:0] lamp[2];
    int tm[2];
    int owner, kind, k;
    if (m_phase == 7) return {3'd7, 3'b100, 3'b100, 7'd0, 7'd0};
    if (m_phase == 6) begin
      lamp[0] = {1'b0, m_blink, 1'b0};
      return {3'd6, lamp[0], lamp[0], 7'd0, 7'd0};
    end
    owner = m_phase / 3;
    kind  = m_phase % 3;
    for (int d = 0; d < 2; d++) begin
      if (owner == d && kind == 0)      lamp[d] = 3'b001;
      else if (owner == d && kind == 1) lamp[d] = 3'b010;
      else                              lamp[d] = 3'b100;
      tm[d] = m_cnt;
      if (!(owner == d && kind < 2)) begin
        k = (m_phase + 1) % 6;
        while (k != 3 * d) begin
          tm[d] += dur[k];
          k = (k + 1) % 6;
        end
      end
    end
    return {3'(m_phase), lamp[0], lamp[1], 7'(tm[0]), 7'(tm[1])};
  endfunction

  // One clock: model follows the edge, DUT compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_cycle", int'({st, tf0, tf1, t0, t1}), int'(model_out()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outs(input string name, input int e_st, input int e_tf0,
                            input int e_tf1, input int e_t0, input int e_t1);
    check({name, "_state"}, int'(st), e_st);
    check({name, "_tf0"}, int'(tf0), e_tf0);
    check({name, "_tf1"}, int'(tf1), e_tf1);
    check({name, "_timer0"}, int'(t0), e_t0);
    check({name, "_timer1"}, int'(t1), e_t1);
  endtask

  initial begin
    int n;
    dur = '{G0_T, Y_T, AR_T, G1_T, Y_T, AR_T};
    tab[0] = '{0,  3'd0, 3'b001, 3'b100, 7'd9,  7'd13};
    tab[1] = '{9,  3'd0, 3'b001, 3'b100, 7'd0,  7'd4};
    tab[2] = '{10, 3'd1, 3'b010, 3'b100, 7'd2,  7'd3};
    tab[3] = '{12, 3'd1, 3'b010, 3'b100, 7'd0,  7'd1};
    tab[4] = '{13, 3'd2, 3'b100, 3'b100, 7'd17, 7'd0};
    tab[5] = '{14, 3'd3, 3'b100, 3'b001, 7'd16, 7'd12};
    tab[6] = '{26, 3'd3, 3'b100, 3'b001, 7'd4,  7'd0};
    tab[7] = '{27, 3'd4, 3'b100, 3'b010, 7'd3,  7'd2};
    tab[8] = '{30, 3'd5, 3'b100, 3'b100, 7'd0,  7'd14};
    tab[9] = '{31, 3'd0, 3'b001, 3'b100, 7'd9,  7'd13};

    rst_n = 1'b0; en = 1'b1; night = 1'b0; ped = 2'b00;
    en4 = 1'b1; night4 = 1'b0; ped4 = 2'b00;
    model_reset();

    // Full default cycle from the constant table
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      while (n < tab[i].at) begin cycle(); n++; end
      check_outs($sformatf("table%0d", i), int'(tab[i].st), int'(tab[i].tf0),
                 int'(tab[i].tf1), int'(tab[i].t0), int'(tab[i].t1));
    end

    // Pedestrian truncation of G0, then ignored once CNT <= PED_MIN
    do_reset();
    cycle(); cycle();
    check("ped_pre_timer0", int'(t0), 7);
    ped = 2'b01; cycle(); ped = 2'b00;
    check("ped_timer0", int'(t0), 2);
    check("ped_timer1", int'(t1), 6);
    ped = 2'b01; cycle(); ped = 2'b00;
    check("ped_low_ignored", int'(t0), 1);
    cycle();
    check("ped_still_g0", int'(st), 0);
    cycle();
    check("ped_y0_entered", int'(st), 1);
    do_reset();
    ped = 2'b10; cycle(); ped = 2'b00;
    check("ped1_in_g0_ignored", int'(t0), 8);

    // Night mode entry at end of AR0, blinking, exit through AR1
    do_reset();
    night = 1'b1;
    for (int i = 0; i < 13; i++) cycle();
    check("night_ar0_state", int'(st), 2);
    cycle();
    check_outs("night_on", 6, 3'b010, 3'b010, 0, 0);
    cycle();
    check_outs("night_blink_off", 6, 3'b000, 3'b000, 0, 0);
    cycle();
    check("night_blink_on", int'(tf0), 3'b010);
    night = 1'b0; cycle();
    check_outs("night_exit_ar1", 5, 3'b100, 3'b100, 0, 14);
    cycle();
    check_outs("night_back_g0", 0, 3'b001, 3'b100, 9, 13);

    // Prescaled instance: freeze with EN low mid-G1
    do_reset();
    for (int i = 0; i < 60; i++) cycle();
    check("div4_state_g1", int'(st4), 3);
    check("div4_timer1", int'(t41), 11);
    en4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("div4_frozen_t1", int'(t41), 11);
      check("div4_frozen_t0", int'(t40), 15);
      check("div4_frozen_tf", int'({tf40, tf41}), int'({3'b100, 3'b001}));
    end
    en4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("div4_wait_tick", int'(t41), 11);
    end
    cycle();
    check("div4_tick_dec", int'(t41), 10);

    // Asynchronous reset in Y1
    do_reset();
    for (int i = 0; i < 28; i++) cycle();
    check("arst_in_y1", int'(st), 4);
    #2 rst_n = 1'b0;
    #1 check_outs("arst_immediate", 0, 3'b001, 3'b100, 9, 13);
    cycle();
    rst_n = 1'b1;
    cycle();
    check_outs("arst_restart", 0, 3'b001, 3'b100, 8, 12);

    // Corrupted state encoding recovers through AR1 even with EN low
    @(negedge clk);
    force dut.state_r = traffic_light_ctl_gen_pkg::ST_BAD;
    #1 check_outs("bad_state_lamps", 7, 3'b100, 3'b100, 0, 0);
    release dut.state_r;
    m_phase = 7;
    en = 1'b0;
    cycle();
    check_outs("bad_to_ar1", 5, 3'b100, 3'b100, 0, 14);
    en = 1'b1;
    cycle();
    check_outs("bad_then_g0", 0, 3'b001, 3'b100, 9, 13);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      ped = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 149) == 0) night = ~night;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctl_gen.md
TRAFFIC_LIGHT_CTL_GEN -- requirements
Module: traffic_light_ctl_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): TW, 7, timer output width; G0_TIME, 10, dir-0 green ticks; G1_TIME, 13, dir-1 green ticks; Y_TIME, 3, yellow ticks; AR_TIME, 1, all-red ticks; PED_MIN, 2, truncated-green counter value; TICK_DIV, 1, CLK cycles per tick.
REQ-002 The parameters SHALL be legal only when all *_TIME values are >= 1, TICK_DIV >= 1, PED_MIN < min(G0_TIME, G1_TIME), and max(G0_TIME, G1_TIME) + G0_TIME + Y_TIME + AR_TIME <= 2^TW.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 EN  in  1  1 = run; 0 = freeze prescaler, phase counter, state and blink.
REQ-006 NIGHT  in  1  level request for flashing-yellow mode.
REQ-007 PED_REQ  in  2  bit k = pedestrian request that shortens the green of direction k.
REQ-008 TIMER0, TIMER1  out  TW  per-direction countdown display.
REQ-009 TF0, TF1  out  3  lamps {R,Y,G}: 100 red, 010 yellow, 001 green.
REQ-010 STATE  out  3  current phase: G0=0, Y0=1, AR0=2, G1=3, Y1=4, AR1=5, NIGHT=6.

Function
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 while EN=1, and tick SHALL be 1 on the cycle it wraps (every cycle when TICK_DIV=1).
REQ-012 Each phase SHALL load the phase counter CNT with duration-1; CNT SHALL decrement on each tick; on a tick with CNT=0 the FSM SHALL advance and load the next duration-1.
REQ-013 The phase order SHALL be G0 -> Y0 -> AR0 -> G1 -> Y1 -> AR1 -> G0, with durations G0_TIME, Y_TIME, AR_TIME, G1_TIME, Y_TIME, AR_TIME.
REQ-014 The lamp outputs SHALL be: G0 TF0=001 TF1=100; Y0 010/100; AR0 100/100; G1 100/001; Y1 100/010; AR1 100/100.
REQ-015 The timer of the non-red (or phase-owning) direction SHALL equal CNT.
REQ-016 The timer of the red direction SHALL show ticks-1 until its green: G0 TIMER1=CNT+Y+AR; Y0 TIMER1=CNT+AR; AR0 TIMER1=CNT and TIMER0=CNT+G1+Y+AR; G1, Y1 and AR1 are mirrored using G0.
REQ-017 TF0, TF1, TIMER0, TIMER1 and STATE SHALL be combinational decodes of the registered state, CNT and blink, with zero added latency.
REQ-018 PED_REQ[k] sampled high in Gk with CNT>PED_MIN and EN=1 SHALL set CNT to PED_MIN on the next edge, taking priority over a same-cycle tick decrement; it SHALL be ignored in all other cases.
REQ-019 NIGHT is evaluated only at the end of AR0 or AR1 (tick and CNT=0): if NIGHT=1 the FSM SHALL enter NIGHT with blink=1 instead of the next green.
REQ-020 In NIGHT, blink SHALL toggle on each tick; TF0=TF1={0,blink,0}; TIMER0=TIMER1=0.
REQ-021 In NIGHT, a tick with NIGHT=0 SHALL move the FSM to AR1 with CNT=AR_TIME-1, and the FSM SHALL then go to G0.
REQ-022 Illegal STATE encoding 7 SHALL drive both lamps 100 and SHALL move to AR1 with CNT=AR_TIME-1 on the next edge, independent of EN.
REQ-023 Timer sums SHALL be computed at TW+1 bits and truncated to TW bits; legal parameters never overflow.

Reset
REQ-024 RST_N=0 SHALL immediately force STATE=G0, CNT=G0_TIME-1, prescaler=0 and blink=0, so TF0=001, TF1=100, TIMER0=G0_TIME-1 and TIMER1=G0_TIME-1+Y_TIME+AR_TIME (defaults: 9 and 13).
REQ-025 Reset release SHALL take effect at the first rising CLK edge with RST_N=1, and a mid-phase reset SHALL discard any pending pedestrian truncation or NIGHT request.

Verification
REQ-026 Defaults, EN=1, run 31 ticks -> TIMER0/TIMER1 traces 9/13 ... 0/4; Y0 2/3 ... 0/1; AR0 17/0; G1 16/12 ... 4/0; Y1 3/2; AR1 0/14; G0 9/13 at tick 31.
REQ-027 In G0 with TIMER0=7, pulse PED_REQ[0] for one cycle -> next cycle TIMER0=2 and TIMER1=6; Y0 entered 3 ticks later; PED_REQ[1] in G0 has no effect.
REQ-028 Assert NIGHT during G0 -> normal sequence through AR0, then STATE=6 with TF0=TF1=010, then 000 on the next tick, alternating; deassert -> AR1 (100/100, TIMER1=14), then G0.
REQ-029 Set TICK_DIV=4 and toggle EN low for 5 cycles mid-G1 -> CNT changes only every 4 enabled cycles and all outputs are frozen while EN=0.
REQ-030 Assert RST_N low asynchronously mid-Y1 -> outputs are 001/100 with 9/13 before the next CLK edge, and the normal sequence restarts after release.
REQ-031 Force STATE=7 -> both lamps 100, and the following sequence is AR1 then G0.
